ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port synchronous SoC RAM.
- Shares the RAM between the instruction-fetch port (read-only) and the load/store port (read/write). Arbitration is round-robin.
- Holds the RAM address stable across the issue and response cycles, and performs byte-lane alignment of read data, write data and write mask.
- Range-checks every request and bounds every transaction with a timeout, so neither requester can hang.

Parameters:
- BASE, 32'h0000_0000, byte address of the first RAM byte.
- SIZE_BYTES, 8192, RAM size in bytes; in-range means BASE <= addr < BASE+SIZE_BYTES.
- TIMEOUT, 15, WAIT-state cycles without RAM valid before an error response; must be >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_ireq  in  1  instruction-port request.
- i_iaddr  in  32  instruction-port byte address.
- o_igrant  out  1  instruction request accepted this cycle.
- o_ivalid  out  1  instruction response pulse.
- o_idata  out  32  instruction read data, valid with o_ivalid.
- o_ierr  out  1  instruction error, valid with o_ivalid.
- i_dreq  in  1  data-port request.
- i_dwe  in  1  1 = write, 0 = read.
- i_daddr  in  32  data-port byte address.
- i_dmask  in  4  byte mask, LSB-aligned (4'b0001 = byte, 4'b0011 = half, 4'b1111 = word).
- i_dwdata  in  32  write data, LSB-aligned.
- o_dgrant  out  1  data request accepted this cycle.
- o_dvalid  out  1  data response pulse (reads and writes).
- o_drdata  out  32  data read data.
- o_derr  out  1  data error, valid with o_dvalid.
- o_ram_rd  out  1  RAM read strobe.
- o_ram_wr  out  1  RAM write strobe.
- o_ram_addr  out  32  RAM address; bits [1:0] are always 0.
- o_ram_wrmask  out  4  RAM write mask, already lane-shifted.
- o_ram_data  out  32  RAM write data, already lane-shifted.
- i_ram_rd_valid  in  1  RAM read-result valid.
- i_ram_wr_valid  in  1  RAM write-complete valid.
- i_ram_data  in  32  RAM read word.

Behaviour:
- **Reset** (clk edge with rst = 1): state IDLE, last-grant = D (so I wins the first tie), timeout counter 0.
  - All o_* outputs are 0 during and after reset until a new transaction.
  - Reset mid-transaction aborts it silently: no response is produced and RAM strobes drop the next cycle.
- **Concurrency:** one transaction in flight; no pipelining.
- **States:** IDLE, ISSUE, WAIT, ERR.
- **IDLE:**
  - Candidates are the ports with req = 1. A single candidate wins.
  - If both request, the winner is the port opposite last-grant.
  - Winner's grant = 1 for this cycle only; its fields are latched and last-grant is updated.
  - Next state: ISSUE if the address is in range, ERR otherwise.
  - No grant is given in any other state; requesters hold req until granted and may drop it after.
- **ISSUE (1 cycle):** drive the RAM from the latched fields.
  - o_ram_addr = {addr[31:2], 2'b00}.
  - o_ram_rd = ~we, o_ram_wr = we.
  - o_ram_wrmask = (mask << addr[1:0]) truncated to 4 bits; mask bits shifted out are dropped.
  - o_ram_data = wdata << (8*addr[1:0]).
  - Instruction-port transactions: we = 0.
  - Next state: WAIT.
- **WAIT:**
  - Strobes are 0; o_ram_addr, o_ram_wrmask and o_ram_data stay held at the latched values.
  - If (~we & i_ram_rd_valid) | (we & i_ram_wr_valid):
    - Owner's valid = 1 and err = 0 in this same cycle.
    - Read data = i_ram_data >> (8*addr[1:0]), zero-filled; write responses return data 0.
    - Next state: IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: owner valid = 1, err = 1, data 0; next state IDLE.
  - The counter clears on entry to WAIT.
- **ERR (1 cycle):** owner valid = 1, err = 1, data 0; RAM untouched; next state IDLE.
- **Latency:** grant cycle N, response cycle N+2 for a nominal RAM; error response at N+1 for out-of-range.
- **Throughput:** the next grant is possible in the response cycle + 1, i.e. a new grant every 3 cycles minimum.
- **Idle outputs:** valid/err/data outputs are 0 except in the response cycle. RAM strobes are 1 only in ISSUE. The non-owner port's valid is never asserted.
- **Range check:** compares the full 32-bit address; BASE+SIZE_BYTES must not overflow 32 bits.

Test Plan:
- I read only: reset, i_iaddr = 0x10 with RAM word[4] = 0xDEADBEEF → o_igrant at N, o_ivalid at N+2 with o_idata = 0xDEADBEEF, o_ierr = 0.
- Unaligned byte write then read: D write addr 0x21, mask 0001, wdata 0xAB → o_ram_addr 0x20, wrmask 0010, data 0x0000AB00. Read-back of 0x21 → o_drdata low byte 0xAB.
- Simultaneous requests held for 4 transactions → grants alternate I, D, I, D starting with I after reset; each response goes only to its owner.
- Out-of-range: D read at BASE+SIZE_BYTES → o_dvalid and o_derr at N+1, o_ram_rd/o_ram_wr stay 0.
- Timeout: RAM valid tied 0, I read in range → o_ivalid = 1, o_ierr = 1 exactly TIMEOUT WAIT cycles after entering WAIT; next request is granted normally.
- Reset in WAIT: assert rst one cycle during WAIT → no o_ivalid/o_dvalid; all outputs 0; next request completes normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port sync RAM between fetch and load/store ports.
// Grant at N, response at N+2 (N+1 for out-of-range); WAIT is bounded by TIMEOUT.
module ram_arbiter #(
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int unsigned SIZE_BYTES = 8192,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ireq,
    input  logic [31:0] i_iaddr,
    output logic        o_igrant,
    output logic        o_ivalid,
    output logic [31:0] o_idata,
    output logic        o_ierr,
    input  logic        i_dreq,
    input  logic        i_dwe,
    input  logic [31:0] i_daddr,
    input  logic [3:0]  i_dmask,
    input  logic [31:0] i_dwdata,
    output logic        o_dgrant,
    output logic        o_dvalid,
    output logic [31:0] o_drdata,
    output logic        o_derr,
    output logic        o_ram_rd,
    output logic        o_ram_wr,
    output logic [31:0] o_ram_addr,
    output logic [3:0]  o_ram_wrmask,
    output logic [31:0] o_ram_data,
    input  logic        i_ram_rd_valid,
    input  logic        i_ram_wr_valid,
    input  logic [31:0] i_ram_data
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last_d;
    logic            r_owner_d;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_mask;
    logic [31:0]     r_wdata;
    logic [CW-1:0]   r_cnt;

    logic            w_any;
    logic            w_pick_d;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_off;
    logic            w_in_range;
    logic [4:0]      w_shift;
    logic            w_done;
    logic            w_tmo;
    logic            w_resp;
    logic            w_err;
    logic [31:0]     w_rsp_data;

    assign w_any      = i_ireq | i_dreq;
    assign w_pick_d   = i_dreq & (~i_ireq | ~r_last_d);
    assign w_sel_addr = w_pick_d ? i_daddr : i_iaddr;
    // Addresses below BASE wrap to a huge offset, so one unsigned compare covers both bounds.
    assign w_off      = w_sel_addr - BASE;
    assign w_in_range = w_off < 32'(SIZE_BYTES);
    assign w_shift    = {r_addr[1:0], 3'b000};
    assign w_done     = r_we ? i_ram_wr_valid : i_ram_rd_valid;
    assign w_tmo      = r_cnt == CW'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_igrant     = 1'b0;
        o_dgrant     = 1'b0;
        o_ram_rd     = 1'b0;
        o_ram_wr     = 1'b0;
        o_ram_addr   = '0;
        o_ram_wrmask = '0;
        o_ram_data   = '0;
        w_resp       = 1'b0;
        w_err        = 1'b0;
        w_rsp_data   = '0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        o_igrant = ~w_pick_d;
                        o_dgrant = w_pick_d;
                        w_next   = w_in_range ? ISSUE : ERR;
                    end
                end
                ISSUE: begin
                    o_ram_rd     = ~r_we;
                    o_ram_wr     = r_we;
                    o_ram_addr   = {r_addr[31:2], 2'b00};
                    o_ram_wrmask = r_mask << r_addr[1:0];
                    o_ram_data   = r_wdata << w_shift;
                    w_next       = WAIT;
                end
                WAIT: begin
                    o_ram_addr   = {r_addr[31:2], 2'b00};
                    o_ram_wrmask = r_mask << r_addr[1:0];
                    o_ram_data   = r_wdata << w_shift;
                    if (w_done) begin
                        w_resp     = 1'b1;
                        w_rsp_data = r_we ? 32'h0 : (i_ram_data >> w_shift);
                        w_next     = IDLE;
                    end else if (w_tmo) begin
                        w_resp = 1'b1;
                        w_err  = 1'b1;
                        w_next = IDLE;
                    end
                end
                ERR: begin
                    w_resp = 1'b1;
                    w_err  = 1'b1;
                    w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
        o_ivalid = w_resp & ~r_owner_d;
        o_ierr   = w_err & ~r_owner_d;
        o_idata  = r_owner_d ? 32'h0 : w_rsp_data;
        o_dvalid = w_resp & r_owner_d;
        o_derr   = w_err & r_owner_d;
        o_drdata = r_owner_d ? w_rsp_data : 32'h0;
    end

    // Request fields are captured on the grant edge; the fetch port never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d  <= 1'b1;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_mask    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_last_d  <= w_pick_d;
                r_owner_d <= w_pick_d;
                r_we      <= w_pick_d & i_dwe;
                r_addr    <= w_sel_addr;
                r_mask    <= w_pick_d ? i_dmask : 4'b0000;
                r_wdata   <= w_pick_d ? i_dwdata : 32'h0;
            end
            r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
        end
    end

endmodule
